wrap_counter: RTL and testbench
===============================

Name: wrap_counter

Overview:
- Free-running modulo counter: counts 0, 1, …, max, then wraps to 0, advancing once per clock.
- The wrap limit `_m_max` is a runtime input, not a constant.
- Used as a generic cycle/sequence counter. Output is the registered count value.

Parameters:
- WIDTH, 8, bit width of the `_m_max` input and of the count output.

Ports:
- `_m_clk`  input  1  rising-edge clock.
- `_m_rst_n`  input  1  asynchronous, active-low reset.
- `_m_max`  input  WIDTH  inclusive upper bound of the count (unsigned).
- `__output`  output  WIDTH  current count, registered.
- `__wrap`  output  1  combinational; high while `__output >= _m_max` (next edge wraps to 0).

Behaviour:
- Reset:
  - `_m_rst_n` low clears the count to 0 immediately, with no clock required.
  - While reset is asserted, `__output = 0`.
  - On deassertion, `__output` holds 0 until the first rising edge after release.
- Each rising `_m_clk` edge, reset inactive:
  - if `count >= _m_max`, count <= 0;
  - else count <= count + 1.
- Latency: 1 cycle. `__output` is the register directly, with no combinational path from `_m_max` to `__output`.
- Arithmetic is unsigned, WIDTH bits. The `>=` compare guarantees no overflow past `_m_max`.
- `_m_max = 0`: count stays at 0; `__wrap` stays high.
- `_m_max = 2^WIDTH-1` (255 at default): full-range count, 255 -> 0.
- `_m_max` lowered below the current count mid-operation: the next edge goes to 0, never counting up through the remaining range.
- `_m_max` raised mid-operation: counting continues upward to the new bound.
- `_m_max` is sampled every cycle; a change takes effect at the next edge.
- Reset asserted mid-count: count returns to 0 asynchronously. Counting restarts at 0 -> 1 on the first edge after release.
- `__wrap` = (count >= `_m_max`), purely combinational from the register and `_m_max`.

Optional Feature:
- Macro: `WRAP_COUNTER_ENABLE_EN`.
- Defined:
  - Adds input `_m_en` (1 bit).
  - The count advances or wraps only on edges where `_m_en = 1`; when `_m_en = 0` it holds.
  - `__wrap` is gated: `__wrap` = `_m_en` && (count >= `_m_max`).
  - Reset behaviour is unchanged.
- Undefined:
  - No `_m_en` port; the counter advances every edge.

Decomposition:
- Shared package `wrap_counter_pkg`:
  - `WRAP_COUNTER_WIDTH_DEFAULT = 8`;
  - typedef `count_t` = logic [WIDTH-1:0] at the default width.
- No sub-module: the next-state logic (compare, increment, mux) stays inline in one always block plus combinational assigns.

Test Plan:
- Basic wrap:
  - Stimulus: `_m_max = 2`, hold `_m_rst_n = 0` for 2 cycles, release at a falling edge.
  - Required: `__output = 0` at release, then 1, 2, 0, 1 on successive cycles; `__wrap` high only when output is 2.
- `_m_max = 0`: after reset, `__output = 0` for 10 cycles; `__wrap = 1` throughout.
- Full range:
  - Stimulus: `_m_max = 255`, run 256 cycles.
  - Required: output reaches 255, then 0 on the next edge; no value is skipped.
- Max lowered:
  - Stimulus: `_m_max = 10`, count to 7, then set `_m_max = 3`.
  - Required: next edge gives 0, then 1, 2, 3, 0.
- Async reset mid-count:
  - Stimulus: `_m_max = 5`, count at 4; pulse `_m_rst_n` low between clock edges.
  - Required: `__output = 0` before the next edge; after release, 0 -> 1 -> 2.
- With `WRAP_COUNTER_ENABLE_EN`:
  - Stimulus: `_m_max = 3`, `_m_en` toggling 1,0,1,1,0,1.
  - Required: output sequence 1,1,2,3,3,0; `__wrap` is never high while `_m_en = 0`.

Source files
------------

// File: rtl/wrap_counter_pkg.sv
// Shared types and defaults for the wrap_counter modulo counter.
package wrap_counter_pkg;

    localparam int unsigned WRAP_COUNTER_WIDTH_DEFAULT = 8;

    typedef logic [WRAP_COUNTER_WIDTH_DEFAULT-1:0] count_t;

endpackage

// File: rtl/wrap_counter.sv
// Free-running modulo counter 0..max with a runtime bound; output is the register itself.
// Define WRAP_COUNTER_ENABLE_EN to add a count-enable input that also gates the wrap flag.
module wrap_counter
    import wrap_counter_pkg::*;
#(
    parameter int unsigned WIDTH = WRAP_COUNTER_WIDTH_DEFAULT
) (
    input  logic             _m_clk,
    input  logic             _m_rst_n,
    input  logic [WIDTH-1:0] _m_max,
`ifdef WRAP_COUNTER_ENABLE_EN
    input  logic             _m_en,
`endif
    output logic [WIDTH-1:0] __output,
    output logic             __wrap
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_max;
    logic             advance;

    // >= rather than == so a lowered bound snaps straight back to 0.
    assign at_max = (count_q >= _m_max);

`ifdef WRAP_COUNTER_ENABLE_EN
    assign advance = _m_en;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        count_d = count_q;
        if (advance) begin
            count_d = at_max ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge _m_clk or negedge _m_rst_n) begin
        if (!_m_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign __output = count_q;
    assign __wrap   = advance && at_max;

endmodule

// File: tb/tb_wrap_counter.sv
// Randomized self-checking bench for wrap_counter against a cycle-level arithmetic model.
module tb_wrap_counter;
    import wrap_counter_pkg::*;

    localparam int unsigned W = WRAP_COUNTER_WIDTH_DEFAULT;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] max_v = '0;
    logic         en    = 1'b1;
    logic [W-1:0] out;
    logic         wrap;

    int n_chk  = 0;
    int n_fail = 0;
    int model  = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    wrap_counter #(.WIDTH(W)) dut (
        ._m_clk   (clk),
        ._m_rst_n (rst_n),
        ._m_max   (max_v),
`ifdef WRAP_COUNTER_ENABLE_EN
        ._m_en    (en),
`endif
        .__output (out),
        .__wrap   (wrap)
    );

    // Model: the count is a plain integer stepped by the modulo rule on each edge.
    always @(posedge clk) begin
        if (!rst_n) model = 0;
        else if (en) model = (model >= int'(max_v)) ? 0 : model + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_count", 32'(out), 32'(model));
            check("model_wrap", 32'(wrap), 32'(en && (model >= int'(max_v))));
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model = 0;
        #1;
        check("async_reset_clear", 32'(out), 0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Basic wrap with max = 2
        max_v = 8'd2;
        #1 chk_on = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("basic_at_release", 32'(out), 0);
        next(); check("basic_1", 32'(out), 1); check("basic_wrap_lo", 32'(wrap), 0);
        next(); check("basic_2", 32'(out), 2); check("basic_wrap_hi", 32'(wrap), 1);
        next(); check("basic_0", 32'(out), 0);
        next(); check("basic_1b", 32'(out), 1);

        // max = 0 holds at zero with wrap asserted
        max_v = 8'd0;
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            next();
            check("max0_count", 32'(out), 0);
            check("max0_wrap", 32'(wrap), 1);
        end

        // Full range 0..255 then 0
        max_v = 8'd255;
        pulse_reset();
        for (int k = 1; k <= 256; k++) begin
            next();
            check("full_range", 32'(out), 32'(k % 256));
        end

        // Bound lowered below the current count
        max_v = 8'd10;
        pulse_reset();
        repeat (7) next();
        check("lower_at7", 32'(out), 7);
        max_v = 8'd3;
        next(); check("lower_0", 32'(out), 0);
        next(); check("lower_1", 32'(out), 1);
        next(); check("lower_2", 32'(out), 2);
        next(); check("lower_3", 32'(out), 3);
        next(); check("lower_wrap0", 32'(out), 0);

        // Async reset mid-count
        max_v = 8'd5;
        pulse_reset();
        repeat (4) next();
        check("mid_at4", 32'(out), 4);
        pulse_reset();
        check("mid_released", 32'(out), 0);
        next(); check("mid_1", 32'(out), 1);
        next(); check("mid_2", 32'(out), 2);

`ifdef WRAP_COUNTER_ENABLE_EN
        begin
            int en_seq [6] = '{1, 0, 1, 1, 0, 1};
            int exp_seq[6] = '{1, 1, 2, 3, 3, 0};
            max_v = 8'd3;
            pulse_reset();
            for (int i = 0; i < 6; i++) begin
                en = en_seq[i][0];
                next();
                check("enable_seq", 32'(out), 32'(exp_seq[i]));
            end
            en = 1'b1;
        end
`endif

        // Randomized phase: small bounds mostly, occasional full-range bounds and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) max_v = W'($urandom_range(0, 255));
            else if ($urandom_range(0, 3) == 0) max_v = W'($urandom_range(0, 15));
`ifdef WRAP_COUNTER_ENABLE_EN
            en = ($urandom_range(0, 3) != 0);
`endif
            if ($urandom_range(0, 99) == 0) pulse_reset();
            next();
        end
        en = 1'b1;

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
